// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared fetch-path types: program counter, instruction word and the
// {pc, instr} entry carried from the ROM read port to decode.
package fetch_prefetch_queue_pkg;

  typedef logic [7:0]  ProgramCounter;
  typedef logic [31:0] Instruction;

  typedef struct packed {
    ProgramCounter pc;
    Instruction    instr;
  } FetchEntry;

  localparam ProgramCounter FETCH_RESET_PC = 8'h00;

  // Saturating 8-bit add, used so the discard statistic never wraps to zero.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[8]) begin
      sat_add8 = 8'hFF;
    end else begin
      sat_add8 = sum[7:0];
    end
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch entries; occupancy is tracked with an explicit
// counter so full and empty never rely on pointer equality.
module fetch_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  FetchEntry               push_entry,
  input  logic                    pop,
  input  logic                    clear,
  output logic [$clog2(DEPTH):0]  count,
  output FetchEntry               head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  FetchEntry     mem_q [DEPTH];
  FetchEntry     mem_d [DEPTH];
  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [PW-1:0] tail_ptr_q, tail_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy; clear overrides push/pop.
  always_comb begin
    mem_d      = mem_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    if (clear) begin
      head_ptr_d = '0;
      tail_ptr_d = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        mem_d[tail_ptr_q] = push_entry;
        tail_ptr_d        = tail_ptr_q + PW'(1'b1);
      end else begin
        tail_ptr_d = tail_ptr_q;
      end
      if (pop) begin
        head_ptr_d = head_ptr_q + PW'(1'b1);
      end else begin
        head_ptr_d = head_ptr_q;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers; reset also scrubs storage so nothing stale can resurface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      mem_q      <= mem_d;
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  assign count = count_q;
  assign head  = (count_q == '0) ? FetchEntry'('0) : mem_q[head_ptr_q];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, reads the combinational InstROM one word
// per cycle and queues {pc, instr} for decode; redirects flush and restart.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned   DEPTH    = 4,
  parameter ProgramCounter RESET_PC = FETCH_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [7:0]             rom_addr,
  input  logic [31:0]            rom_instr,
  input  logic                   redirect,
  input  logic [7:0]             redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [7:0]             out_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             flushed
);

  localparam int unsigned   CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  ProgramCounter fetch_pc_q, fetch_pc_d;
  logic [7:0]    flushed_q, flushed_d;
  logic [CW-1:0] count_s;
  logic [7:0]    drop_s;
  logic          pop_s;
  logic          push_s;
  FetchEntry     push_entry_s;
  FetchEntry     head_s;

  assign out_valid    = (count_s != '0);
  assign pop_s        = out_valid & out_ready;
  assign push_s       = !redirect & ((count_s < FULL_COUNT) | pop_s);
  assign push_entry_s = '{pc: fetch_pc_q, instr: rom_instr};
  // An entry popped in the redirect cycle was delivered, so it is not counted as discarded.
  assign drop_s       = 8'(count_s) - {7'b0000000, pop_s};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .clear      (redirect),
    .count      (count_s),
    .head       (head_s)
  );

  // Fetch PC and discard-counter next state; redirect takes priority over push.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    flushed_d  = flushed_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      flushed_d  = sat_add8(flushed_q, drop_s);
    end else if (push_s) begin
      fetch_pc_d = fetch_pc_q + 8'h01;
      flushed_d  = flushed_q;
    end else begin
      fetch_pc_d = fetch_pc_q;
      flushed_d  = flushed_q;
    end
  end

  // Fetch PC and statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      flushed_q  <= 8'h00;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      flushed_q  <= flushed_d;
    end
  end

  assign rom_addr  = fetch_pc_q;
  assign out_instr = head_s.instr;
  assign out_pc    = head_s.pc;
  assign count     = count_s;
  assign flushed   = flushed_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a combinational ROM model
// where word k holds 32'h1000_0000 + k.
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic [2:0]  count;
  logic [7:0]  flushed;

  int checks = 0;
  int errors = 0;

  fetch_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_instr   (rom_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .count       (count),
    .flushed     (flushed)
  );

  assign rom_instr = 32'h1000_0000 + {24'h000000, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    out_ready   = ready;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [7:0] wrap_seq [4];

  initial begin
    wrap_seq[0] = 8'hFE;
    wrap_seq[1] = 8'hFF;
    wrap_seq[2] = 8'h00;
    wrap_seq[3] = 8'h01;

    // Reset values, then streaming with decode always ready.
    rst = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; out_ready = 1'b1;
    tick();
    check_val("rst_count", {29'd0, count}, 32'd0);
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_instr", out_instr, 32'd0);
    check_val("rst_pc", {24'd0, out_pc}, 32'd0);
    check_val("rst_flushed", {24'd0, flushed}, 32'd0);
    check_val("rst_romaddr", {24'd0, rom_addr}, 32'd0);
    rst = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      check_val("stream_valid", {31'd0, out_valid}, 32'd1);
      check_val("stream_pc", {24'd0, out_pc}, k);
      check_val("stream_instr", out_instr, 32'h1000_0000 + k);
      check_val("stream_count", {29'd0, count}, 32'd1);
      tick();
    end

    // Stall until full, then drain with simultaneous push/pop at full.
    do_reset(1'b0);
    repeat (10) tick();
    check_val("stall_count", {29'd0, count}, 32'd4);
    check_val("stall_romaddr", {24'd0, rom_addr}, 32'd4);
    check_val("stall_pc", {24'd0, out_pc}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_val("drain_pc", {24'd0, out_pc}, k);
      check_val("full_count", {29'd0, count}, 32'd4);
      check_val("full_romaddr", {24'd0, rom_addr}, 32'd4 + k);
      tick();
    end

    // Redirect with three entries queued and decode stalled.
    do_reset(1'b0);
    repeat (3) tick();
    check_val("pre_redir_count", {29'd0, count}, 32'd3);
    redirect = 1'b1; redirect_pc = 8'h40;
    #1;
    check_val("redir_same_cycle_valid", {31'd0, out_valid}, 32'd1);
    tick();
    redirect = 1'b0;
    check_val("redir_n1_valid", {31'd0, out_valid}, 32'd0);
    check_val("redir_n1_flushed", {24'd0, flushed}, 32'd3);
    check_val("redir_n1_romaddr", {24'd0, rom_addr}, 32'h40);
    tick();
    check_val("redir_n2_valid", {31'd0, out_valid}, 32'd1);
    check_val("redir_n2_pc", {24'd0, out_pc}, 32'h40);
    out_ready = 1'b1;
    tick();
    check_val("redir_n3_pc", {24'd0, out_pc}, 32'h41);

    // Redirect during a pop, then PC wrap FF -> 00.
    redirect = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    check_val("pop_redir_flushed", {24'd0, flushed}, 32'd3);
    check_val("pop_redir_valid", {31'd0, out_valid}, 32'd0);
    check_val("pop_redir_romaddr", {24'd0, rom_addr}, 32'hFE);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_val("wrap_pc", {24'd0, out_pc}, {24'd0, wrap_seq[k]});
      check_val("wrap_instr", out_instr, 32'h1000_0000 + {24'd0, wrap_seq[k]});
      tick();
    end

    // Back-to-back redirects: only the last target is fetched.
    out_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 8'h80;
    tick();
    redirect_pc = 8'h90;
    tick();
    redirect = 1'b0;
    check_val("b2b_flushed", {24'd0, flushed}, 32'd4);
    check_val("b2b_valid", {31'd0, out_valid}, 32'd0);
    check_val("b2b_romaddr", {24'd0, rom_addr}, 32'h90);
    tick();
    check_val("b2b_pc", {24'd0, out_pc}, 32'h90);
    tick();
    check_val("b2b_hold_pc", {24'd0, out_pc}, 32'h90);
    check_val("b2b_count", {29'd0, count}, 32'd2);

    // Discard counter saturates at 255 (70 flushes of 4 entries).
    do_reset(1'b0);
    for (int i = 0; i < 70; i++) begin
      redirect = 1'b0;
      repeat (4) tick();
      redirect = 1'b1; redirect_pc = 8'h10;
      tick();
      if (i == 1) check_val("sat_mid_flushed", {24'd0, flushed}, 32'd8);
    end
    redirect = 1'b0;
    check_val("sat_flushed", {24'd0, flushed}, 32'd255);

    // Asynchronous reset mid-stream with two entries queued.
    do_reset(1'b0);
    repeat (2) tick();
    check_val("mid_pre_count", {29'd0, count}, 32'd2);
    check_val("mid_pre_romaddr", {24'd0, rom_addr}, 32'd2);
    rst = 1'b0;
    #1;
    check_val("async_count", {29'd0, count}, 32'd0);
    check_val("async_valid", {31'd0, out_valid}, 32'd0);
    check_val("async_romaddr", {24'd0, rom_addr}, 32'd0);
    check_val("async_pc", {24'd0, out_pc}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check_val("restart_valid", {31'd0, out_valid}, 32'd1);
    check_val("restart_pc", {24'd0, out_pc}, 32'd0);
    check_val("restart_instr", out_instr, 32'h1000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
